// File: rtl/hier_path_receiver.sv
// Reassembles a serial per-level index stream into one packed path word, depth and error flag.
// Latency: out_valid rises the cycle after the in_last beat is accepted.
// Backpressure: in_ready is low while a finished path is held; the path is held until out_ready.
module hier_path_receiver #(
    parameter int IDX_W     = 3,
    parameter int MAX_DEPTH = 10,
    parameter int FANOUT    = 5,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IDX_W-1:0]           in_idx,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MAX_DEPTH*IDX_W-1:0] out_path,
    output logic [DEPTH_W-1:0]         out_depth,
    output logic                       out_err
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SKIP    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int PW = MAX_DEPTH * IDX_W;

    state_t               state_q, state_d;
    logic [PW-1:0]        path_q,  path_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_q,   err_d;

    logic                 accept;
    logic                 idx_ok;
    logic                 room;

    // Ready is withheld while a path waits downstream and during reset.
    assign in_ready = (state_q != HOLD) && !rst;
    assign accept   = in_valid && in_ready;

    // Unsigned range check; an index equal to FANOUT is already illegal.
    assign idx_ok = ({{(32-IDX_W){1'b0}}, in_idx} < 32'(FANOUT));
    assign room   = (depth_q < DEPTH_W'(MAX_DEPTH));

    // Next-state and datapath: store legal beats, flag the first bad one, skip the rest.
    always_comb begin
        state_d = state_q;
        path_d  = path_q;
        depth_d = depth_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (idx_ok && room) begin
                        path_d[int'(depth_q)*IDX_W +: IDX_W] = in_idx;
                        depth_d = depth_q + DEPTH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end else if (!(idx_ok && room)) begin
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (accept && in_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    path_d  = '0;
                    depth_d = '0;
                    err_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and path registers; reset drops any partial or pending path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            path_q  <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_path  = path_q;
    assign out_depth = depth_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_hier_path_receiver.sv
module tb_hier_path_receiver;

    localparam int IDX_W     = 3;
    localparam int MAX_DEPTH = 10;
    localparam int FANOUT    = 5;
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [IDX_W-1:0]           in_idx;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [MAX_DEPTH*IDX_W-1:0] out_path;
    logic [DEPTH_W-1:0]         out_depth;
    logic                       out_err;

    int total = 0;
    int bad   = 0;

    int beats[$];
    longint exp_path;
    int     exp_depth;
    int     exp_err;

    hier_path_receiver #(
        .IDX_W(IDX_W), .MAX_DEPTH(MAX_DEPTH), .FANOUT(FANOUT), .DEPTH_W(DEPTH_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_path(out_path), .out_depth(out_depth), .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: levels are stored in order until the first illegal or excess
    // beat; everything from there on only marks the path as malformed.
    task automatic model();
        exp_path  = 0;
        exp_depth = 0;
        exp_err   = 0;
        foreach (beats[i]) begin
            if (exp_err == 0) begin
                if (beats[i] < FANOUT && exp_depth < MAX_DEPTH) begin
                    exp_path  = exp_path + (longint'(beats[i]) << (IDX_W * exp_depth));
                    exp_depth = exp_depth + 1;
                end else begin
                    exp_err = 1;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic drive_beat(input int idx, input bit last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_last  = last;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("beat_accept_timeout", longint'(guard < 50), 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends the queued beats, then checks the held path through its handshake.
    task automatic send_path(input int stall, input string tag);
        model();
        out_ready = (stall == 0);
        foreach (beats[i]) drive_beat(beats[i], i == beats.size() - 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_vld"},   longint'(out_valid), 1);
        check({tag, "_rdy0"},  longint'(in_ready), 0);
        check({tag, "_path"},  longint'(out_path), exp_path);
        check({tag, "_depth"}, longint'(out_depth), exp_depth);
        check({tag, "_err"},   longint'(out_err), exp_err);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_hold_vld"},  longint'(out_valid), 1);
            check({tag, "_hold_rdy"},  longint'(in_ready), 0);
            check({tag, "_hold_path"}, longint'(out_path), exp_path);
            check({tag, "_hold_dep"},  longint'(out_depth), exp_depth);
            check({tag, "_hold_err"},  longint'(out_err), exp_err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_vld"},  longint'(out_valid), 0);
        check({tag, "_post_rdy"},  longint'(in_ready), 1);
        check({tag, "_post_dep"},  longint'(out_depth), 0);
        @(negedge clk);
        check({tag, "_idle_vld"},  longint'(out_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_path",  longint'(out_path), 0);
        check("rst_out_depth", longint'(out_depth), 0);
        check("rst_out_err",   longint'(out_err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Nominal path
        beats = '{0, 0, 0, 0, 0, 0, 1, 2};
        send_path(0, "nominal");
        check("nominal_const_path", exp_path, 64'h440000);

        // Illegal index, remaining beats skipped
        beats = '{1, 5, 3, 4};
        send_path(0, "illegal");
        check("illegal_const_path", exp_path, 64'h1);

        // Overflow: eleven beats of 4
        beats = {};
        for (int i = 0; i < 11; i++) beats.push_back(4);
        send_path(0, "overflow");

        // Backpressure for five cycles
        beats = '{2, 1, 0};
        send_path(5, "bp");

        // Reset mid-path
        out_ready = 1'b1;
        drive_beat(3, 1'b0);
        drive_beat(3, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", longint'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_depth", longint'(out_depth), 0);
        check("midrst_rdy",   longint'(in_ready), 1);
        beats = '{4};
        send_path(0, "midrst");

        // Reset while holding drops the pending path
        beats = '{1, 2};
        out_ready = 1'b0;
        drive_beat(1, 1'b0);
        drive_beat(2, 1'b1);
        in_valid = 1'b0;
        check("holdrst_vld", longint'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("holdrst_vld_gone", longint'(out_valid), 0);
        check("holdrst_path",     longint'(out_path), 0);

        // Back-to-back single-beat paths with in_valid held high
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_idx   = 3'd0;
        in_last  = 1'b1;
        check("b2b_a_rdy", longint'(in_ready), 1);
        @(negedge clk);
        check("b2b_a_vld",   longint'(out_valid), 1);
        check("b2b_a_rdy0",  longint'(in_ready), 0);
        check("b2b_a_path",  longint'(out_path), 0);
        check("b2b_a_depth", longint'(out_depth), 1);
        check("b2b_a_err",   longint'(out_err), 0);
        in_idx = 3'd4;
        @(negedge clk);
        check("b2b_gap_vld", longint'(out_valid), 0);
        check("b2b_gap_rdy", longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_b_vld",   longint'(out_valid), 1);
        check("b2b_b_rdy0",  longint'(in_ready), 0);
        check("b2b_b_path",  longint'(out_path), 4);
        check("b2b_b_depth", longint'(out_depth), 1);
        check("b2b_b_err",   longint'(out_err), 0);
        @(negedge clk);
        check("b2b_end_vld", longint'(out_valid), 0);

        // Randomized paths against the reference model
        for (int p = 0; p < 40; p++) begin
            int len;
            len   = $urandom_range(1, 13);
            beats = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0) beats.push_back($urandom_range(0, 7));
                else beats.push_back($urandom_range(0, FANOUT - 1));
            end
            send_path($urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
